// File: rtl/lfsr_game_timer.sv
// Galois LFSR random source plus a prescaled one-shot/periodic interval timer,
// used by the memory game for symbol draws and player response windows.
//
// state | meaning
// IDLE  | timer stopped, Remaining held at 0, Busy low
// RUN   | prescaler counting, Remaining ticks left in the current interval
module lfsr_game_timer #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'h002C),
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter int unsigned      DIV   = 50000,
    parameter int unsigned      CW    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             RandEn,
    input  logic             SeedLd,
    input  logic [WIDTH-1:0] SeedIn,
    output logic [WIDTH-1:0] Rand,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Periodic,
    input  logic [CW-1:0]    Duration,
    output logic             Tick,
    output logic             Done,
    output logic             Busy,
    output logic [CW-1:0]    Remaining
);

    localparam int unsigned    PW       = $clog2(DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic [CW-1:0]   dur_q;
    logic            periodic_q;
    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] seed_safe;

    always_comb begin
        lfsr_step    = '0;
        lfsr_step[0] = Rand[WIDTH-1];
        for (int i = 1; i < WIDTH; i++) begin
            lfsr_step[i] = Rand[i-1] ^ (TAPS[i] & Rand[WIDTH-1]);
        end
    end

    // An all-zero seed would lock the LFSR up, so fall back to SEED.
    assign seed_safe = (SeedIn == '0) ? SEED : SeedIn;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rand       <= SEED;
            state      <= IDLE;
            prescaler  <= '0;
            dur_q      <= '0;
            periodic_q <= 1'b0;
            Tick       <= 1'b0;
            Done       <= 1'b0;
            Busy       <= 1'b0;
            Remaining  <= '0;
        end else begin
            if (SeedLd) begin
                Rand <= seed_safe;
            end else if (RandEn) begin
                Rand <= lfsr_step;
            end

            Tick <= 1'b0;
            Done <= 1'b0;

            if (Abort) begin
                state     <= IDLE;
                Busy      <= 1'b0;
                Remaining <= '0;
                prescaler <= '0;
            end else if (Start) begin
                prescaler <= '0;
                if (Duration != '0) begin
                    state      <= RUN;
                    dur_q      <= Duration;
                    periodic_q <= Periodic;
                    Remaining  <= Duration;
                    Busy       <= 1'b1;
                end else begin
                    // Zero-length interval expires immediately.
                    state     <= IDLE;
                    Remaining <= '0;
                    Busy      <= 1'b0;
                    Done      <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        prescaler <= '0;
                    end
                    RUN: begin
                        if (prescaler == PRE_LAST) begin
                            prescaler <= '0;
                            Tick      <= 1'b1;
                            if (Remaining == CW'(1)) begin
                                Done <= 1'b1;
                                if (periodic_q) begin
                                    Remaining <= dur_q;
                                end else begin
                                    Remaining <= '0;
                                    Busy      <= 1'b0;
                                    state     <= IDLE;
                                end
                            end else begin
                                Remaining <= Remaining - CW'(1);
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_game_timer.sv
// Scoreboard bench for lfsr_game_timer: driver pushes model expectations per
// cycle, an independent monitor pops and compares after each rising edge.
module tb_lfsr_game_timer;

    localparam int unsigned WIDTH = 4;
    localparam logic [3:0]  TAPS  = 4'b0010;
    localparam logic [3:0]  SEED  = 4'hF;
    localparam int unsigned DIV   = 4;
    localparam int unsigned CW    = 8;

    logic            Clk;
    logic            Rst;
    logic            RandEn;
    logic            SeedLd;
    logic [3:0]      SeedIn;
    logic [3:0]      Rand;
    logic            Start;
    logic            Abort;
    logic            Periodic;
    logic [7:0]      Duration;
    logic            Tick;
    logic            Done;
    logic            Busy;
    logic [7:0]      Remaining;

    lfsr_game_timer #(
        .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .DIV(DIV), .CW(CW)
    ) dut (
        .Clk(Clk), .Rst(Rst), .RandEn(RandEn), .SeedLd(SeedLd), .SeedIn(SeedIn),
        .Rand(Rand), .Start(Start), .Abort(Abort), .Periodic(Periodic),
        .Duration(Duration), .Tick(Tick), .Done(Done), .Busy(Busy),
        .Remaining(Remaining)
    );

    typedef struct {
        logic [3:0] rnd;
        logic       tick;
        logic       done;
        logic       busy;
        logic [7:0] rem;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: LFSR as polynomial multiply-by-x, timer as elapsed-time arithmetic.
    logic [3:0] m_rand;
    bit         m_active = 0;
    int         m_t0, m_dur, n = 0;
    bit         m_per;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        logic [3:0] fb;
        fb = s[3] ? (TAPS | 4'b0001) : 4'b0000;
        return {s[2:0], 1'b0} ^ fb;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic step(input logic rst, input logic ren, input logic sld,
                        input logic [3:0] sin, input logic st, input logic ab,
                        input logic per, input logic [7:0] dur);
        exp_t e;
        int   el, k;
        @(negedge Clk);
        Rst = rst; RandEn = ren; SeedLd = sld; SeedIn = sin;
        Start = st; Abort = ab; Periodic = per; Duration = dur;
        n++;
        e.rnd = '0; e.tick = 0; e.done = 0; e.busy = 0; e.rem = '0;
        if (rst) begin
            m_rand   = SEED;
            m_active = 0;
        end else begin
            if (sld)      m_rand = (sin == 4'h0) ? SEED : sin;
            else if (ren) m_rand = lfsr_next(m_rand);
            if (ab) begin
                m_active = 0;
            end else if (st) begin
                if (dur != 0) begin
                    m_active = 1; m_t0 = n; m_dur = int'(dur); m_per = per;
                    e.busy = 1; e.rem = dur;
                end else begin
                    m_active = 0; e.done = 1;
                end
            end else if (m_active) begin
                el = n - m_t0;
                k  = el / int'(DIV);
                e.tick = (el % int'(DIV) == 0);
                if (m_per) begin
                    e.busy = 1;
                    e.rem  = 8'(m_dur - (k % m_dur));
                    e.done = e.tick && (k % m_dur == 0);
                end else if (k >= m_dur) begin
                    e.done = 1; m_active = 0;
                end else begin
                    e.busy = 1;
                    e.rem  = 8'(m_dur - k);
                end
            end
        end
        e.rnd = m_rand;
        sb.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 4'h0, 0, 0, 0, 8'd0);
    endtask

    task automatic go(input logic per, input logic [7:0] dur);
        step(0, 0, 0, 4'h0, 1, 0, per, dur);
    endtask

    // Monitor: compares every presented output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rand",      int'(Rand),      int'(e.rnd));
                chk("tick",      int'(Tick),      int'(e.tick));
                chk("done",      int'(Done),      int'(e.done));
                chk("busy",      int'(Busy),      int'(e.busy));
                chk("remaining", int'(Remaining), int'(e.rem));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] seq [16];
        seq = '{4'hF, 4'hD, 4'h9, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE, 4'hF};
        Rst = 1; RandEn = 0; SeedLd = 0; SeedIn = 0;
        Start = 0; Abort = 0; Periodic = 0; Duration = 0;
        m_rand = SEED;

        step(1, 0, 0, 4'h0, 0, 0, 0, 8'd0);
        step(1, 0, 0, 4'h0, 0, 0, 0, 8'd0);

        // Full LFSR period, also checked against a literal sequence table.
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 0, 4'h0, 0, 0, 0, 8'd0);
            @(posedge Clk);
            #2;
            chk("lfsr_seq", int'(Rand), int'(seq[i]));
        end

        step(0, 0, 1, 4'h5, 0, 0, 0, 8'd0);
        step(0, 0, 1, 4'h0, 0, 0, 0, 8'd0);
        step(0, 1, 0, 4'h0, 0, 0, 0, 8'd0);
        step(0, 1, 1, 4'h9, 0, 0, 0, 8'd0);
        idle(1);

        go(0, 8'd3);
        idle(14);

        go(1, 8'd2);
        idle(30);
        step(0, 0, 0, 4'h0, 0, 1, 0, 8'd0);
        idle(2);

        go(0, 8'd0);
        idle(3);

        go(0, 8'd3);
        idle(5);
        go(0, 8'd3);
        idle(15);

        go(0, 8'd3);
        idle(2);
        step(0, 0, 0, 4'h0, 1, 1, 0, 8'd2);
        idle(14);
        step(0, 0, 0, 4'h0, 1, 1, 1, 8'd2);
        idle(2);

        // Abort landing exactly on an expiry edge.
        go(0, 8'd1);
        idle(3);
        step(0, 0, 0, 4'h0, 0, 1, 0, 8'd0);
        idle(2);

        go(1, 8'd3);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 4'h0, 0, 0, 0, 8'd0);
        step(1, 1, 0, 4'h0, 0, 0, 0, 8'd0);
        go(0, 8'd2);
        idle(10);

        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 4)));
        end

        idle(2);
        @(posedge Clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_game_timer.md
Name: lfsr_game_timer

Overview:
Parametrised successor to the 16-bit free-running LFSR used by the memory game. It combines two functions:
- A Galois LFSR random source with configurable width, taps, seed load, step enable and lock-up protection.
- A prescaled interval timer with a one-shot or periodic mode, run/abort control and an expiry pulse.

Game control uses it to draw random sequence symbols and to time player response windows (e.g. 1 ms ticks).

Parameters:
WIDTH, 16, LFSR width (>=3)
TAPS, 16'h002C, feedback mask; bit i (i>=1) set => feedback XORed into stage i; stage 0 always receives feedback
SEED, all ones, reset/default seed (must be non-zero)
DIV, 50000, clock cycles per timer tick (>=2)
CW, 16, duration/remaining-count width

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous active-high reset
RandEn  in  1  step LFSR this cycle
SeedLd  in  1  load LFSR from SeedIn
SeedIn  in  WIDTH  seed value
Rand  out  WIDTH  current LFSR state
Start  in  1  start/restart timer
Abort  in  1  cancel timer
Periodic  in  1  mode, sampled with Start
Duration  in  CW  ticks until expiry, sampled with Start
Tick  out  1  one-cycle pulse per elapsed tick while running
Done  out  1  one-cycle expiry pulse
Busy  out  1  timer running
Remaining  out  CW  ticks left

Behaviour:
- Rst=1 at an edge: Rand=SEED, Busy=0, Done=0, Tick=0, Remaining=0, prescaler=0, FSM=IDLE. Reset overrides all other inputs, including mid-run.
- LFSR step (left-shifting Galois, msb = state[WIDTH-1]):
  - next[0] = msb
  - next[i] = state[i-1] ^ (TAPS[i] & msb)
- LFSR input priority:
  - SeedLd loads SeedIn; if SeedIn==0, SEED is loaded instead (no lock-up).
  - Otherwise RandEn steps.
  - Otherwise hold.
  - SeedLd together with RandEn: load only.
- Timer FSM states IDLE, RUN; registered outputs.
- IDLE:
  - Start with Duration!=0: latch Duration and Periodic, Remaining=Duration, prescaler=0, go to RUN; Busy=1 from the next cycle.
  - Start with Duration==0: Done=1 for one cycle, stay IDLE, Remaining=0.
- RUN, prescaler increments each cycle.
  - When prescaler==DIV-1: prescaler wraps to 0, Tick=1 for the next cycle, Remaining decrements.
  - At the tick where Remaining==1:
    - Done=1 for one cycle, coincident with Tick.
    - Periodic latched: Remaining reloads the latched Duration; stay RUN, no dead cycle.
    - One-shot: Remaining=0, Busy=0, go to IDLE.
- Latency: with Start sampled at edge 0, Tick rises after edges k·DIV and Done after edge Duration·DIV.
- Start in RUN restarts the timer: reload Duration/Periodic, prescaler=0, no Done for the cancelled interval.
- Abort (any state): go to IDLE next edge, Busy=0, Remaining=0, prescaler=0, no Done/Tick that cycle.
- Abort and Start in the same cycle: Abort wins.
- Abort on an expiry edge: suppresses Done.
- LFSR and timer are independent; both may operate in the same cycle.

Test Plan:
- LFSR sequence: WIDTH=4, TAPS=4'b0010, SEED=4'hF, reset then RandEn=1 -> Rand = F,D,9,1,2,4,8,3,6,C,B…; returns to F after exactly 15 steps; never 0.
- Seed handling: SeedLd with SeedIn=4'h5 -> Rand=5 next cycle. SeedLd with SeedIn=0 -> Rand=F. SeedLd+RandEn in the same cycle -> loaded value, no step.
- One-shot timing: DIV=4, Duration=3, Start at edge 0 -> Tick after edges 4, 8, 12; Remaining 3→2→1→0; Done high only after edge 12; Busy high after edges 1..11, low after 12.
- Periodic: DIV=4, Duration=2, Periodic=1 -> Done after edges 8, 16, 24…; Busy stays 1; Remaining reloads 2 with no gap.
- Zero duration / restart / abort:
  - Duration=0 Start -> Done pulse next cycle, Busy stays 0.
  - Restart at edge 6 of a Duration=3 run -> Done after edge 18 only.
  - Abort+Start together -> IDLE, no Done.
- Reset mid-run: Rst asserted during RUN with Rand≠SEED -> next cycle all outputs at reset values and Rand=SEED; a subsequent Start behaves as from a clean start.
